// File: rtl/cen_gen.sv
// Multi-channel clock-enable generator: per-channel programmable divisor,
// pulse (cen) and toggle (clk_out) outputs, boundary-only divisor updates.
module cen_gen #(
  parameter int                        CHANNELS = 3,
  parameter int                        CNT_W    = 8,
  parameter logic [CHANNELS*CNT_W-1:0] DIV_INIT = {8'd2, 8'd5, 8'd5}
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       ch_en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       div_load,
  input  logic [CHANNELS*CNT_W-1:0] div_value,
  input  logic                      pause,
  input  logic                      resync,
  output logic [CHANNELS-1:0]       cen,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       pend,
  output logic                      all_cen
);

  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [CNT_W-1:0]    cnt_d  [CHANNELS];
  logic [CNT_W-1:0]    div_q  [CHANNELS];
  logic [CNT_W-1:0]    div_d  [CHANNELS];
  logic [CNT_W-1:0]    pval_q [CHANNELS];
  logic [CNT_W-1:0]    pval_d [CHANNELS];
  logic [CHANNELS-1:0] cen_q, cen_d;
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic                all_q, all_d;

  // A programmed divisor of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] div);
    return (div == '0) ? CNT_W'(1) : div;
  endfunction

  function automatic logic at_term(input logic [CNT_W-1:0] cnt,
                                   input logic [CNT_W-1:0] div);
    return cnt == (eff_div(div) - CNT_W'(1));
  endfunction

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pval_d = pval_q;
    cen_d  = '0;
    clk_d  = clk_q;
    pend_d = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (resync) begin
        // Resync realigns phase and commits any waiting divisor at once.
        cnt_d[i]  = '0;
        clk_d[i]  = 1'b0;
        pend_d[i] = 1'b0;
        if (div_load[i])
          div_d[i] = div_value[i*CNT_W +: CNT_W];
        else if (pend_q[i])
          div_d[i] = pval_q[i];
      end else if (pause || !ch_en[i]) begin
        if (div_load[i]) begin
          pval_d[i] = div_value[i*CNT_W +: CNT_W];
          pend_d[i] = 1'b1;
        end
      end else if (at_term(cnt_q[i], div_q[i])) begin
        cnt_d[i]  = '0;
        cen_d[i]  = 1'b1;
        pend_d[i] = 1'b0;
        if (mode[i])
          clk_d[i] = ~clk_q[i];
        // A load landing on the boundary governs the very next period.
        if (div_load[i])
          div_d[i] = div_value[i*CNT_W +: CNT_W];
        else if (pend_q[i])
          div_d[i] = pval_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
        if (div_load[i]) begin
          pval_d[i] = div_value[i*CNT_W +: CNT_W];
          pend_d[i] = 1'b1;
        end
      end
    end
    all_d = (|ch_en) && ((cen_d | ~ch_en) == '1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
        pval_q[i] <= '0;
      end
      cen_q  <= '0;
      clk_q  <= '0;
      pend_q <= '0;
      all_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pval_q <= pval_d;
      cen_q  <= cen_d;
      clk_q  <= clk_d;
      pend_q <= pend_d;
      all_q  <= all_d;
    end
  end

  assign cen     = cen_q;
  assign clk_out = clk_q;
  assign pend    = pend_q;
  assign all_cen = all_q;

endmodule

// File: tb/tb_cen_gen.sv
// Scoreboard bench for cen_gen: per-cycle expected output words are queued as
// stimulus is driven and popped against the DUT outputs one cycle at a time.
module tb_cen_gen;

  logic        clk_sys;
  logic        reset_n;
  logic [2:0]  ch_en, mode, div_load;
  logic [23:0] div_value;
  logic        pause, resync;
  logic [2:0]  cen, clk_out, pend;
  logic        all_cen;

  typedef struct {
    logic [9:0] exp;
    logic [9:0] msk;
  } sb_t;

  sb_t sb_q[$];
  int  cyc;
  int  vectors;
  int  miscompares;

  cen_gen #(.CHANNELS(3), .CNT_W(8), .DIV_INIT({8'd2, 8'd5, 8'd5})) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ch_en    (ch_en),
    .mode     (mode),
    .div_load (div_load),
    .div_value(div_value),
    .pause    (pause),
    .resync   (resync),
    .cen      (cen),
    .clk_out  (clk_out),
    .pend     (pend),
    .all_cen  (all_cen)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic logic [9:0] pk(input logic [2:0] c, input logic [2:0] k,
                                    input logic [2:0] p, input logic a);
    return {a, p, k, c};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic drive_idle();
    ch_en     = 3'b111;
    mode      = 3'b001;
    div_load  = 3'b000;
    div_value = 24'd0;
    pause     = 1'b0;
    resync    = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    drive_idle();
    reset_n = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if (obs !== 10'd0) begin
        miscompares++;
        $display("FAIL reset c=%0d got=%b want=%b", c, obs, 10'd0);
      end
    end
  endtask

  task automatic test_defaults();
    sb_t e;
    logic [9:0] obs;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      e.exp = pk({c % 2 == 0, c % 5 == 0, c % 5 == 0},
                 {2'b00, (c / 5) % 2 == 1}, 3'b000, c % 10 == 0);
      e.msk = '1;
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if ((obs & e.msk) !== (e.exp & e.msk)) begin
        miscompares++;
        $display("FAIL defaults c=%0d got=%b want=%b", cyc, obs & e.msk, e.exp & e.msk);
      end
    end
  endtask

  task automatic test_div_change();
    sb_t e;
    logic [9:0] obs;
    do_reset();
    for (int c = 1; c <= 14; c++) begin
      div_load  = (c == 2) ? 3'b010 : 3'b000;
      div_value = {8'd0, 8'd3, 8'd0};
      e.exp = pk({1'b0, (c == 5) || (c > 5 && (c - 5) % 3 == 0), 1'b0},
                 3'b000, {1'b0, c >= 2 && c < 5, 1'b0}, 1'b0);
      e.msk = 10'b0_010_010_010;
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if ((obs & e.msk) !== (e.exp & e.msk)) begin
        miscompares++;
        $display("FAIL div_change c=%0d got=%b want=%b", cyc, obs & e.msk, e.exp & e.msk);
      end
    end
    div_load = 3'b000;
  endtask

  task automatic test_div_zero_and_term_load();
    sb_t e;
    logic [9:0] obs;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      div_load  = (c == 1) ? 3'b001 : (c == 5) ? 3'b010 : 3'b000;
      div_value = (c == 5) ? {8'd0, 8'd2, 8'd0} : 24'd0;
      e.exp = pk({c % 2 == 0, (c == 5) || (c >= 7 && c % 2 == 1), c >= 5},
                 {2'b00, c >= 5 && c % 2 == 1},
                 {2'b00, c >= 1 && c <= 4}, 1'b0);
      e.msk = '1;
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if ((obs & e.msk) !== (e.exp & e.msk)) begin
        miscompares++;
        $display("FAIL div_zero c=%0d got=%b want=%b", cyc, obs & e.msk, e.exp & e.msk);
      end
    end
    div_load = 3'b000;
  endtask

  task automatic test_pause();
    sb_t e;
    logic [9:0] obs;
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      pause = (c >= 7 && c <= 13);
      e.exp = pk({(c == 2 || c == 4 || c == 6 || (c >= 15 && c % 2 == 1)),
                  (c == 5 || c == 17), (c == 5 || c == 17)},
                 {2'b00, c >= 5 && c <= 16}, 3'b000, c == 17);
      e.msk = '1;
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if ((obs & e.msk) !== (e.exp & e.msk)) begin
        miscompares++;
        $display("FAIL pause c=%0d got=%b want=%b", cyc, obs & e.msk, e.exp & e.msk);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_resync();
    sb_t e;
    logic [9:0] obs;
    do_reset();
    for (int c = 1; c <= 18; c++) begin
      div_load  = (c == 6) ? 3'b010 : 3'b000;
      div_value = {8'd0, 8'd4, 8'd0};
      pause     = (c == 7);
      resync    = (c == 7);
      e.exp = pk({(c == 2 || c == 4 || c == 6 || (c >= 9 && c % 2 == 1)),
                  (c == 5 || c == 11 || c == 15),
                  (c == 5 || c == 12 || c == 17)},
                 {2'b00, (c >= 5 && c <= 6) || (c >= 12 && c <= 16)},
                 {1'b0, c == 6, 1'b0}, 1'b0);
      e.msk = '1;
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if ((obs & e.msk) !== (e.exp & e.msk)) begin
        miscompares++;
        $display("FAIL resync c=%0d got=%b want=%b", cyc, obs & e.msk, e.exp & e.msk);
      end
    end
    drive_idle();
  endtask

  task automatic test_ch_en();
    sb_t e;
    logic [9:0] obs;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      ch_en = (c <= 3) ? 3'b011 : 3'b111;
      e.exp = pk({(c == 5 || c == 7 || c == 9), (c == 5 || c == 10), (c == 5 || c == 10)},
                 {2'b00, c >= 5 && c < 10}, 3'b000, c == 5);
      e.msk = '1;
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if ((obs & e.msk) !== (e.exp & e.msk)) begin
        miscompares++;
        $display("FAIL ch_en c=%0d got=%b want=%b", cyc, obs & e.msk, e.exp & e.msk);
      end
    end
    ch_en = 3'b111;
  endtask

  task automatic test_async_reset();
    sb_t e;
    logic [9:0] obs;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      div_load  = (c == 6) ? 3'b010 : 3'b000;
      div_value = {8'd0, 8'd3, 8'd0};
      tick();
    end
    div_load = 3'b000;
    vectors++;
    if (clk_out[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre_clk got=%b want=1", clk_out[0]);
    end
    vectors++;
    if (pend[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL async_pre_pend got=%b want=1", pend[1]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    obs = {all_cen, pend, clk_out, cen};
    vectors++;
    if (obs !== 10'd0) begin
      miscompares++;
      $display("FAIL async_reset got=%b want=%b", obs, 10'd0);
    end
    tick();
    reset_n = 1'b1;
    cyc     = 0;
    for (int c = 1; c <= 10; c++) begin
      e.exp = pk({1'b0, c % 5 == 0, 1'b0}, 3'b000, 3'b000, 1'b0);
      e.msk = 10'b0_010_000_010;
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {all_cen, pend, clk_out, cen};
      vectors++;
      if ((obs & e.msk) !== (e.exp & e.msk)) begin
        miscompares++;
        $display("FAIL async_after c=%0d got=%b want=%b", cyc, obs & e.msk, e.exp & e.msk);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset_n     = 1'b0;
    drive_idle();
    test_reset();
    test_defaults();
    test_div_change();
    test_div_zero_and_term_load();
    test_pause();
    test_resync();
    test_ch_en();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cen_gen.md
Name: cen_gen

Overview:
- Parametrised multi-channel clock-enable generator; replaces the hard-coded divide-by-5 and toggle logic that derives the CPU, FDC and pixel enables from clk_sys.
- Each channel has a runtime-programmable divisor and a pulse or toggle output mode.
- Divisor changes are glitch-free: they apply only at a period boundary.
- Adds pause (turbo/halt) and a global phase resync.
- Sits between the PLL outputs and the machine core.

Parameters:
- CHANNELS, 3, number of independent enable channels.
- CNT_W, 8, divisor/counter width per channel.
- DIV_INIT, {8'd2,8'd5,8'd5}, flat CHANNELS*CNT_W reset divisors; channel 0 in the LSBs.

Ports:
- clk_sys  in  1  system clock (40 MHz nominal).
- reset_n  in  1  asynchronous, active-low reset.
- ch_en  in  CHANNELS  per-channel run enable.
- mode  in  CHANNELS  0 = pulse output (cen), 1 = toggle output (50% duty clk_out).
- div_load  in  CHANNELS  1-cycle strobe: capture the channel's slice of div_value as pending divisor.
- div_value  in  CHANNELS*CNT_W  new divisors, one slice per channel.
- pause  in  1  freeze all counters.
- resync  in  1  1-cycle strobe: realign all channels to phase 0.
- cen  out  CHANNELS  1-cycle enable pulse per period.
- clk_out  out  CHANNELS  toggled at each period end; period is 2*div.
- pend  out  CHANNELS  a loaded divisor is waiting for a boundary.
- all_cen  out  1  all channels with ch_en=1 pulse cen in the same cycle; 0 if no channel is enabled.

Behaviour:
- Reset (reset_n=0, async):
  - counters = 0; div_reg = DIV_INIT slices; pend_reg = 0.
  - cen = 0, clk_out = 0, pend = 0, all_cen = 0.
- Effective divisor d = max(div_reg, 1); a written 0 behaves as 1.
- Per channel, each clk_sys edge with ch_en=1, pause=0 and no resync:
  - If cnt == d-1 (terminal): cnt <= 0, cen <= 1, clk_out <= ~clk_out (only when mode=1). If pend is set, div_reg <= pend_val and pend <= 0.
  - Else: cnt <= cnt+1, cen <= 0.
- Output timing:
  - cen is registered; pulse period = d cycles; first pulse appears d cycles after reset release.
  - d=1 gives cen high continuously and clk_out toggling every cycle.
- mode=0: clk_out holds its value. mode changes take effect at the next terminal count; cen is produced in both modes.
- div_load[i]=1: pend_val <= slice i, pend <= 1.
  - Load in the same cycle as a terminal count: the new value bypasses pending and governs the very next period; pend stays 0.
  - Second load before the boundary overwrites pend_val; last value wins.
- ch_en=0: counter held, cen=0, clk_out held; a pending divisor stays pending. Re-enable resumes from the held count.
- pause=1: all counters frozen, cen forced 0 in the next cycle, clk_out held. div_load is still accepted into pending.
- resync=1 (highest priority, wins over pause and ch_en):
  - all counters <= 0, clk_out <= 0, cen <= 0.
  - pending divisors apply immediately; pend <= 0.
  - Next cen for each channel follows d cycles later.
- Divisor shrinking below the current count cannot occur mid-period because changes only apply at a boundary. div_reg is never written mid-period except by resync, which also zeroes the counter.
- all_cen is registered together with cen (same cycle).
- Counter arithmetic is CNT_W-bit unsigned; cnt never exceeds d-1. Maximum d = 2^CNT_W - 1.

Test Plan:
- Reset release, defaults, mode=3'b001, all ch_en=1:
  - ch0 (d=5) cen every 5 cycles, first at cycle 5; clk_out[0] period 10 cycles, 50% duty.
  - ch2 (d=2) cen every 2 cycles; clk_out[1] and clk_out[2] stay 0.
  - all_cen every 10 cycles.
- ch1 running d=5, div_load with value 3 at cnt=1:
  - pend[1]=1 until the terminal count; remaining period stays 5.
  - Following cen intervals are 3; pend clears on the boundary cycle.
- div_load value 0 on ch0: after the boundary, cen[0] is constantly 1 and clk_out[0] toggles every cycle.
  - Load exactly on the terminal cycle: the next interval already uses the new divisor and pend never asserts.
- pause held 7 cycles mid-period on d=5: no cen during the pause; clk_out held.
  - After release, the period resumes with the remaining count; total interval = 5+7.
- resync asserted together with pause and a pending divisor 4 on ch1:
  - counters and clk_out return to 0; pend clears.
  - cen[1] 4 cycles later, cen[0] 5 cycles later.
- Assert reset_n=0 asynchronously mid-period while clk_out=1:
  - all outputs 0 immediately without a clock edge.
  - Divisors return to DIV_INIT and pending loads are discarded.
